// File: rtl/flog_pkg.sv
// Shared types and constants for the bfloat16 log2 packer.
package flog_pkg;

  localparam int EXP_BIAS = 127;

  localparam logic [15:0] QNAN    = 16'h7FC0;
  localparam logic [15:0] NEG_INF = 16'hFF80;
  localparam logic [15:0] POS_INF = 16'h7F80;

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    NORM,
    ROUND,
    DONE
  } state_t;

endpackage

// File: rtl/flog_pack.sv
// Packs exponent + fractional log2 into a bfloat16 log2(x); define FLOG_RNE_EN for round-to-nearest-even.
// Latency: 2 edges for specials/zero, s+3 edges for normal operands (s = normalisation shifts).
// No backpressure: in_valid is only sampled in IDLE; out_valid is a one-cycle pulse, busy marks non-IDLE.
module flog_pack #(
  parameter int EXP_BIAS   = flog_pkg::EXP_BIAS,
  parameter int FRAC_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            exp_in,
  input  logic [FRAC_WIDTH-1:0] frac_log,
  input  logic                  is_nan,
  input  logic                  is_zero,
  input  logic                  is_inf,
  input  logic                  is_neg,
  output logic [15:0]           result,
  output logic                  out_valid,
  output logic                  busy
);

  import flog_pkg::*;

  state_t                state;
  logic [7:0]            exp_q;
  logic [FRAC_WIDTH-1:0] frac_q;
  logic                  nan_q, zero_q, inf_q, neg_q;
  logic                  sign;
  logic [15:0]           mag;
  logic [3:0]            s;

  logic [15:0] v;
  logic [15:0] v_abs;
  logic [7:0]  round_exp;

  // Signed Q9.7: unbiased exponent as the integer part, log2 fraction below it.
  assign v         = (({8'h00, exp_q} - 16'(EXP_BIAS)) << FRAC_WIDTH) | 16'(frac_q);
  assign v_abs     = v[15] ? (16'd0 - v) : v;
  assign round_exp = 8'd135 - {4'd0, s};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      result    <= 16'h0000;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      s         <= 4'd0;
      mag       <= 16'h0000;
      sign      <= 1'b0;
      exp_q     <= 8'h00;
      frac_q    <= '0;
      nan_q     <= 1'b0;
      zero_q    <= 1'b0;
      inf_q     <= 1'b0;
      neg_q     <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            exp_q  <= exp_in;
            frac_q <= frac_log;
            nan_q  <= is_nan;
            zero_q <= is_zero;
            inf_q  <= is_inf;
            neg_q  <= is_neg;
            busy   <= 1'b1;
            state  <= CONV;
          end
        end
        CONV: begin
          s <= 4'd0;
          if (nan_q) begin
            result <= QNAN;
            state  <= DONE;
          end else if (zero_q) begin
            result <= NEG_INF;
            state  <= DONE;
          end else if (neg_q) begin
            result <= QNAN;
            state  <= DONE;
          end else if (inf_q) begin
            result <= POS_INF;
            state  <= DONE;
          end else if (v == 16'h0000) begin
            result <= 16'h0000;
            state  <= DONE;
          end else begin
            sign  <= v[15];
            mag   <= v_abs;
            state <= NORM;
          end
        end
        NORM: begin
          // The shift that brings the leading one to bit 15 also leaves NORM,
          // so the exit test looks one bit ahead.
          if (mag[15] || s == 4'd15) begin
            state <= ROUND;
          end else begin
            mag <= mag << 1;
            s   <= s + 4'd1;
            if (mag[14] || s == 4'd14) state <= ROUND;
          end
        end
        ROUND: begin
`ifdef FLOG_RNE_EN
          if (mag[7] && ((|mag[6:0]) || mag[8])) begin
            if (&mag[14:8]) result <= {sign, round_exp + 8'd1, 7'd0};
            else            result <= {sign, round_exp, mag[14:8] + 7'd1};
          end else begin
            result <= {sign, round_exp, mag[14:8]};
          end
`else
          result <= {sign, round_exp, mag[14:8]};
`endif
          state <= DONE;
        end
        DONE: begin
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flog_pack.sv
// Scoreboard bench for flog_pack: expected result/latency queued at acceptance, checked on out_valid.
module tb_flog_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  exp_in;
  logic [6:0]  frac_log;
  logic        is_nan, is_zero, is_inf, is_neg;
  logic [15:0] result;
  logic        out_valid;
  logic        busy;

  flog_pack dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .exp_in   (exp_in),
    .frac_log (frac_log),
    .is_nan   (is_nan),
    .is_zero  (is_zero),
    .is_inf   (is_inf),
    .is_neg   (is_neg),
    .result   (result),
    .out_valid(out_valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    int          lat;
    time         t_acc;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  // Monitor: pops expectations on out_valid, checks pulse width and result hold.
  logic        prev_vld = 1'b0;
  logic [15:0] prev_res = 16'h0;
  time         t_edge;
  always begin
    exp_t e;
    @(posedge clk);
    t_edge = $time;
    #1;
    if (prev_vld) begin
      chk("pulse_len", {31'd0, out_valid}, 32'd0);
      chk("hold", {16'd0, result}, {16'd0, prev_res});
    end
    prev_vld = 1'b0;
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_vld", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk({e.tag, "_res"}, {16'd0, result}, {16'd0, e.res});
        chk({e.tag, "_lat"}, 32'((t_edge - e.t_acc) / 10), 32'(e.lat));
        prev_vld = 1'b1;
        prev_res = e.res;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  // flg = {nan, zero, neg, inf}
  task automatic op(input string tag, input logic [7:0] e, input logic [6:0] f,
                    input logic [3:0] flg, input logic [15:0] res, input int lat);
    exp_t x;
    wait_idle();
    exp_in   = e;
    frac_log = f;
    {is_nan, is_zero, is_neg, is_inf} = flg;
    in_valid = 1'b1;
    @(posedge clk);
    x.res = res; x.lat = lat; x.t_acc = $time; x.tag = tag;
    q.push_back(x);
    @(negedge clk);
    in_valid = 1'b0;
    {is_nan, is_zero, is_neg, is_inf} = 4'b0000;
  endtask

  initial begin
    exp_t x;
    int   n;
    rst = 1'b1; in_valid = 1'b0; exp_in = 8'h00; frac_log = 7'h00;
    is_nan = 1'b0; is_zero = 1'b0; is_inf = 1'b0; is_neg = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_vld", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    op("zero_v",   8'd127, 7'h00, 4'b0000, 16'h0000, 2);
    op("one",      8'd128, 7'h00, 4'b0000, 16'h3F80, 11);
    op("neg_one",  8'd126, 7'h00, 4'b0000, 16'hBF80, 11);
    op("half",     8'd127, 7'h40, 4'b0000, 16'h3F00, 12);
    op("exp1",     8'd1,   7'h00, 4'b0000, 16'hC2FC, 5);
    op("exp254_0", 8'd254, 7'h00, 4'b0000, 16'h42FE, 5);
    op("tie_even", 8'd191, 7'h20, 4'b0000, 16'h4280, 5);
`ifdef FLOG_RNE_EN
    op("max",      8'd254, 7'h7F, 4'b0000, 16'h4300, 5);
    op("tie_odd",  8'd191, 7'h60, 4'b0000, 16'h4282, 5);
`else
    op("max",      8'd254, 7'h7F, 4'b0000, 16'h42FF, 5);
    op("tie_odd",  8'd191, 7'h60, 4'b0000, 16'h4281, 5);
`endif
    op("nan_zero", 8'd5,   7'h11, 4'b1100, 16'h7FC0, 2);
    op("zero_in",  8'd0,   7'h00, 4'b0100, 16'hFF80, 2);
    op("neg_in",   8'd130, 7'h00, 4'b0010, 16'h7FC0, 2);
    op("neg_inf",  8'd255, 7'h00, 4'b0011, 16'h7FC0, 2);
    op("inf_in",   8'd255, 7'h00, 4'b0001, 16'h7F80, 2);

    // in_valid held high while busy: exactly one result, inputs captured at accept.
    wait_idle();
    exp_in = 8'd128; frac_log = 7'h00; in_valid = 1'b1;
    @(posedge clk);
    x.res = 16'h3F80; x.lat = 11; x.t_acc = $time; x.tag = "held";
    q.push_back(x);
    repeat (8) begin
      @(negedge clk);
      exp_in = 8'd5;
    end
    in_valid = 1'b0;

    // Reset during NORM abandons the operation.
    wait_idle();
    exp_in = 8'd128; frac_log = 7'h00; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_result", {16'd0, result}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    repeat (20) @(negedge clk);
    chk("mid_rst_result_late", {16'd0, result}, 32'd0);

    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
